// File: rtl/stream_demux_1_4.sv
// Purpose : 1-to-4 stream demultiplexer; each input beat is steered by in_sel
//           into one of four per-channel FIFOs and presented on that channel.
// Latency : a beat accepted in cycle t is visible on out_valid/out_dN at t+1.
// Backpressure: in_ready drops only when the selected channel is full (head-of-line
//           stall); other channels keep draining independently.
//
// Ports:
//   clk, rst            clock (rising edge) and asynchronous active-high reset
//   in_valid/in_ready   input handshake; in_data payload, in_sel destination 0..3
//   out_valid[3:0]      channel N has a head beat
//   out_ready[3:0]      consumer N takes the head beat this cycle
//   out_d0..out_d3      head data of each channel (0 while empty after reset)
module stream_demux_1_4 #(
  parameter int W     = 4,
  parameter int DEPTH = 2   // power of 2, >= 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic [1:0]   in_sel,
  output logic [3:0]   out_valid,
  input  logic [3:0]   out_ready,
  output logic [W-1:0] out_d0,
  output logic [W-1:0] out_d1,
  output logic [W-1:0] out_d2,
  output logic [W-1:0] out_d3
);

  localparam int            PW       = $clog2(DEPTH);
  localparam int            CW       = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

  logic [3:0]        w_full;
  logic [3:0]        w_push;
  logic [3:0]        w_pop;
  logic [3:0][W-1:0] w_head;

  // Pointer advance with explicit wrap from the last entry back to 0.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  // in_ready looks only at registered fill state of the selected channel, so a
  // pop on a full channel does not open the input in the same cycle and there is
  // no combinational path from out_ready to in_ready.
  assign in_ready = ~w_full[in_sel];

  // One-hot write strobe: only the addressed channel sees the beat.
  always_comb begin
    w_push = '0;
    if (in_valid && in_ready) begin
      w_push[in_sel] = 1'b1;
    end
  end

  // out_ready on an empty channel is ignored.
  assign w_pop = out_valid & out_ready;

  for (genvar n = 0; n < 4; n++) begin : g_ch
    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    assign w_full[n]    = (r_count == CNT_FULL);
    assign out_valid[n] = (r_count != '0);
    assign w_head[n]    = r_mem[r_rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
        for (int i = 0; i < DEPTH; i++) begin
          r_mem[i] <= '0;
        end
      end else begin
        // w_push is already gated by in_ready, so a push never hits a full FIFO.
        if (w_push[n]) begin
          r_mem[r_wr_ptr] <= in_data;
          r_wr_ptr        <= ptr_inc(r_wr_ptr);
        end
        if (w_pop[n]) begin
          r_rd_ptr <= ptr_inc(r_rd_ptr);
        end
        // Simultaneous push and pop leaves the fill level unchanged.
        if (w_push[n] && !w_pop[n]) begin
          r_count <= r_count + CW'(1);
        end else if (!w_push[n] && w_pop[n]) begin
          r_count <= r_count - CW'(1);
        end
      end
    end
  end

  assign out_d0 = w_head[0];
  assign out_d1 = w_head[1];
  assign out_d2 = w_head[2];
  assign out_d3 = w_head[3];

endmodule

// File: tb/tb_stream_demux_1_4.sv
module tb_stream_demux_1_4;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic [1:0]   in_sel = '0;
  logic [3:0]   out_valid;
  logic [3:0]   out_ready = '0;
  logic [W-1:0] out_d0, out_d1, out_d2, out_d3;
  logic [W-1:0] od [4];

  int tests = 0;
  int fails = 0;

  // Per-channel expected-beat queues (circular buffers).
  logic [W-1:0] sb_mem [4][256];
  int           sb_wr [4];
  int           sb_rd [4];

  stream_demux_1_4 #(.W(W), .DEPTH(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_d0    (out_d0),
    .out_d1    (out_d1),
    .out_d2    (out_d2),
    .out_d3    (out_d3)
  );

  assign od[0] = out_d0;
  assign od[1] = out_d1;
  assign od[2] = out_d2;
  assign od[3] = out_d3;

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int sb_size(input int n);
    return sb_wr[n] - sb_rd[n];
  endfunction

  task automatic sb_push(input int n, input logic [W-1:0] d);
    sb_mem[n][sb_wr[n] % 256] = d;
    sb_wr[n]++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] s, input logic [W-1:0] d);
    in_valid = 1'b1;
    in_sel   = s;
    in_data  = d;
  endtask

  // Hold the driven beat until accepted (bounded), record it, then drop in_valid.
  task automatic wait_accept();
    bit done = 1'b0;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk);
      if (in_ready) begin
        sb_push(in_sel, in_data);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: sel %0d got in_ready=0 for 50 cycles, required acceptance", in_sel);
    end
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [1:0] s, input logic [W-1:0] d);
    drive(s, d);
    wait_accept();
  endtask

  // Monitor: every beat taken by a consumer must match the head of its queue.
  always @(negedge clk) begin
    if (!rst) begin
      for (int n = 0; n < 4; n++) begin
        if (out_valid[n]) begin
          if (sb_size(n) == 0) begin
            tests++;
            fails++;
            $display("FAIL spurious_valid: channel %0d out_valid=1, required 0 (nothing queued)", n);
          end else if (out_ready[n]) begin
            chk($sformatf("pop_ch%0d", n), 32'(od[n]), 32'(sb_mem[n][sb_rd[n] % 256]));
            sb_rd[n]++;
          end
        end
      end
    end
  end

  initial begin
    logic [W-1:0] v;

    // 1. Reset then idle.
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    step();
    for (int s = 0; s < 4; s++) begin
      in_sel = 2'(s);
      #1;
      chk($sformatf("t1_in_ready_sel%0d", s), 32'(in_ready), 32'd1);
    end
    chk("t1_out_valid", 32'(out_valid), 32'h0);
    for (int n = 0; n < 4; n++) begin
      chk($sformatf("t1_out_d%0d", n), 32'(od[n]), 32'h0);
    end

    // 2. A,B,C,D to channels 0..3 with all consumers ready: one-hot valid walk.
    step();
    out_ready = 4'hF;
    drive(2'd0, 4'hA);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i > 0) begin
        v = 4'hA + 4'(i - 1);
        chk($sformatf("t2_valid_%0d", i - 1), 32'(out_valid), 32'(4'b0001 << (i - 1)));
        chk($sformatf("t2_data_%0d", i - 1), 32'(od[i - 1]), 32'(v));
      end
      chk($sformatf("t2_in_ready_%0d", i), 32'(in_ready), 32'd1);
      sb_push(i, 4'hA + 4'(i));
      @(posedge clk);
      #1;
      if (i < 3) drive(2'(i + 1), 4'hA + 4'(i + 1));
      else in_valid = 1'b0;
    end
    @(negedge clk);
    chk("t2_valid_3", 32'(out_valid), 32'b1000);
    chk("t2_data_3", 32'(out_d3), 32'hD);
    @(negedge clk);
    chk("t2_drained", 32'(out_valid), 32'h0);

    // 3. Fill channel 2, stall the third beat, release by popping.
    step();
    out_ready = 4'b0000;
    send(2'd2, 4'd7);
    send(2'd2, 4'd10);
    drive(2'd2, 4'd3);
    @(negedge clk);
    chk("t3_full_stall", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    out_ready = 4'b0100;
    @(negedge clk);
    chk("t3_full_while_pop", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("t3_ready_after_pop", 32'(in_ready), 32'd1);
    chk("t3_head_10", 32'(out_d2), 32'd10);
    sb_push(2, 4'd3);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("t3_head_3", 32'(out_d2), 32'd3);
    chk("t3_valid", 32'(out_valid), 32'b0100);
    step();
    out_ready = 4'b0000;

    // 4. Channel 1 full and stalled while channel 0 drains.
    send(2'd1, 4'd1);
    send(2'd1, 4'd2);
    send(2'd0, 4'd5);
    send(2'd0, 4'd6);
    drive(2'd1, 4'd9);
    out_ready = 4'b0001;
    @(negedge clk);
    chk("t4_stall_a", 32'(in_ready), 32'd0);
    chk("t4_valid_a", 32'(out_valid), 32'b0011);
    chk("t4_d0_a", 32'(out_d0), 32'd5);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("t4_stall_b", 32'(in_ready), 32'd0);
    chk("t4_valid_b", 32'(out_valid), 32'b0011);
    chk("t4_d0_b", 32'(out_d0), 32'd6);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("t4_stall_c", 32'(in_ready), 32'd0);
    chk("t4_valid_c", 32'(out_valid), 32'b0010);
    @(posedge clk);
    #1;
    out_ready = 4'b0010;
    wait_accept();
    repeat (3) step();
    @(negedge clk);
    chk("t4_drained", 32'(out_valid), 32'h0);

    // 5. Push and pop on channel 3 in the same cycle at count 1.
    step();
    out_ready = 4'b0000;
    send(2'd3, 4'd1);
    drive(2'd3, 4'hE);
    out_ready = 4'b1000;
    @(negedge clk);
    chk("t5_ready", 32'(in_ready), 32'd1);
    sb_push(3, 4'hE);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 4'b0000;
    in_sel    = 2'd3;
    @(negedge clk);
    chk("t5_valid", 32'(out_valid), 32'b1000);
    chk("t5_head_E", 32'(out_d3), 32'hE);
    chk("t5_count1_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    out_ready = 4'b1000;
    @(posedge clk);
    #1;
    out_ready = 4'b0000;
    @(negedge clk);
    chk("t5_empty", 32'(out_valid), 32'h0);

    // 5b. Random traffic against the scoreboard.
    step();
    for (int c = 0; c < 100; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_sel    = 2'($urandom_range(0, 3));
      in_data   = 4'($urandom_range(0, 15));
      out_ready = 4'($urandom_range(0, 15));
      @(negedge clk);
      if (in_valid && in_ready) sb_push(in_sel, in_data);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 4'hF;
    repeat (4) step();
    @(negedge clk);
    chk("t5_rand_drained", 32'(out_valid), 32'h0);
    for (int n = 0; n < 4; n++) begin
      chk($sformatf("t5_rand_left_ch%0d", n), 32'(sb_size(n)), 32'd0);
    end

    // 6. Reset with two beats queued in every channel.
    step();
    out_ready = 4'b0000;
    for (int n = 0; n < 4; n++) begin
      for (int k = 0; k < 2; k++) begin
        send(2'(n), 4'(n * 4 + k + 1));
      end
    end
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("t6_async_valid", 32'(out_valid), 32'h0);
    for (int n = 0; n < 4; n++) begin
      chk($sformatf("t6_async_d%0d", n), 32'(od[n]), 32'h0);
      sb_rd[n] = sb_wr[n];
    end
    @(negedge clk);
    rst = 1'b0;
    step();
    @(negedge clk);
    chk("t6_no_spurious", 32'(out_valid), 32'h0);
    step();
    send(2'd2, 4'h3);
    send(2'd2, 4'h8);
    @(negedge clk);
    chk("t6_first_valid", 32'(out_valid), 32'b0100);
    chk("t6_first_head", 32'(out_d2), 32'h3);
    step();
    out_ready = 4'b0100;
    repeat (3) step();
    @(negedge clk);
    chk("t6_drained", 32'(out_valid), 32'h0);
    for (int n = 0; n < 4; n++) begin
      chk($sformatf("t6_left_ch%0d", n), 32'(sb_size(n)), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
